// File: rtl/vdp2_pkg.sv
// Shared VDP2 definitions: write-drain FSM states, CPU write-FIFO entry layout, VRAM bank indices.
package vdp2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } drain_state_t;

    localparam int ENTRY_W    = 34;
    localparam int ENTRY_A_HI = 33;
    localparam int ENTRY_A_LO = 16;
    localparam int ENTRY_D_HI = 15;
    localparam int ENTRY_D_LO = 0;

    localparam logic [1:0] BANK_A0 = 2'd0;
    localparam logic [1:0] BANK_A1 = 2'd1;
    localparam logic [1:0] BANK_B0 = 2'd2;
    localparam logic [1:0] BANK_B1 = 2'd3;

endpackage

// File: rtl/vdp2_write_drain.sv
// Drains the CPU write FIFO into the VRAM arbiter, one held entry at a time, in FIFO order.
// Latency: pop on the first edge with FIFO non-empty, VRAM_REQ two edges later when the bank slot is free.
// Backpressure: entry waits in HOLD for BANK_FREE, then REQ/A/D stay frozen until VRAM_ACK.
module vdp2_write_drain
    import vdp2_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [ADDR_W+DATA_W-1:0] FIFO_Q,
    input  logic                     FIFO_EMPTY,
    output logic                     FIFO_RDREQ,
    input  logic [3:0]               BANK_FREE,
    output logic                     VRAM_REQ,
    output logic [1:0]               VRAM_BANK,
    output logic [ADDR_W-1:0]        VRAM_A,
    output logic [DATA_W-1:0]        VRAM_D,
    input  logic                     VRAM_ACK,
    output logic                     BUSY,
    output logic [7:0]               WR_CNT
);

    drain_state_t      state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pop;
    logic [1:0]        bank;

    assign bank = addr_q[ADDR_W-1 -: 2];

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!FIFO_EMPTY) begin
                    pop     = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (BANK_FREE[bank]) begin
                    req_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Bank slot loss is ignored here: the arbiter already owns the request.
                if (VRAM_ACK) begin
                    req_d = 1'b0;
                    cnt_d = cnt_q + 8'd1;
                    if (!FIFO_EMPTY) begin
                        pop     = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            addr_d = FIFO_Q[DATA_W +: ADDR_W];
            data_d = FIFO_Q[0 +: DATA_W];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pop is combinational; masking with RST_N keeps it low while reset is held.
    assign FIFO_RDREQ = pop & RST_N;
    assign VRAM_REQ   = req_q;
    assign VRAM_BANK  = bank;
    assign VRAM_A     = addr_q;
    assign VRAM_D     = data_q;
    assign WR_CNT     = cnt_q;
    assign BUSY       = !FIFO_EMPTY || (state_q != ST_IDLE);

endmodule

// File: tb/tb_vdp2_write_drain.sv
// Directed bench for vdp2_write_drain with a FIFO model, an auto/manual arbiter and a write log.
module tb_vdp2_write_drain;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [33:0] FIFO_Q;
    logic        FIFO_EMPTY;
    logic        FIFO_RDREQ;
    logic [3:0]  BANK_FREE = 4'hF;
    logic        VRAM_REQ;
    logic [1:0]  VRAM_BANK;
    logic [17:0] VRAM_A;
    logic [15:0] VRAM_D;
    logic        VRAM_ACK;
    logic        BUSY;
    logic [7:0]  WR_CNT;

    vdp2_write_drain #(.ADDR_W(18), .DATA_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RDREQ(FIFO_RDREQ), .BANK_FREE(BANK_FREE), .VRAM_REQ(VRAM_REQ),
        .VRAM_BANK(VRAM_BANK), .VRAM_A(VRAM_A), .VRAM_D(VRAM_D),
        .VRAM_ACK(VRAM_ACK), .BUSY(BUSY), .WR_CNT(WR_CNT)
    );

    always #5 CLK = ~CLK;

    // FIFO model
    logic [33:0] fmem [0:511];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign FIFO_EMPTY = (rd_ptr == wr_ptr);
    assign FIFO_Q     = fmem[rd_ptr % 512];
    always @(posedge CLK) if (FIFO_RDREQ && !FIFO_EMPTY) rd_ptr <= rd_ptr + 1;

    // Arbiter model: auto mode acks in the cycle after REQ is seen high
    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;
    logic ack_r    = 1'b0;
    always @(posedge CLK) ack_r <= ack_auto && VRAM_REQ && !ack_r;
    assign VRAM_ACK = ack_r | ack_man;

    // Monitors
    int cyc = 0;
    int nw  = 0;
    logic        bad_pop = 1'b0;
    logic [17:0] log_a [0:511];
    logic [15:0] log_d [0:511];
    int          log_t [0:511];
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (FIFO_RDREQ && FIFO_EMPTY) bad_pop <= 1'b1;
        if (VRAM_REQ && VRAM_ACK) begin
            log_a[nw % 512] <= VRAM_A;
            log_d[nw % 512] <= VRAM_D;
            log_t[nw % 512] <= cyc;
            nw <= nw + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input logic [17:0] a, input logic [15:0] d);
        fmem[wr_ptr % 512] = {a, d};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int k = 0;
        while (!VRAM_REQ && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, VRAM_REQ}, 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int k = 0;
        while (nw < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, (nw >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int base, rd0, cnt0;
        logic stable;
        logic [17:0] a0;
        logic [15:0] d0;

        // Reset state
        #12;
        chk("rst_req", {31'd0, VRAM_REQ}, 32'd0);
        chk("rst_a", {14'd0, VRAM_A}, 32'd0);
        chk("rst_d", {16'd0, VRAM_D}, 32'd0);
        chk("rst_cnt", {24'd0, WR_CNT}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick(2);

        // Single entry, bank A0
        ack_auto = 1'b1;
        rd0 = rd_ptr;
        push(18'h00010, 16'hBEEF);
        #1;
        chk("single_pop", {31'd0, FIFO_RDREQ}, 32'd1);
        tick();
        chk("single_req_e1", {31'd0, VRAM_REQ}, 32'd0);
        chk("single_pop_once", {31'd0, FIFO_RDREQ}, 32'd0);
        tick();
        chk("single_req_e2", {31'd0, VRAM_REQ}, 32'd1);
        chk("single_bank", {30'd0, VRAM_BANK}, 32'd0);
        chk("single_a", {14'd0, VRAM_A}, 32'h00010);
        chk("single_d", {16'd0, VRAM_D}, 32'hBEEF);
        tick(2);
        chk("single_req_drop", {31'd0, VRAM_REQ}, 32'd0);
        chk("single_cnt", {24'd0, WR_CNT}, 32'd1);
        chk("single_busy", {31'd0, BUSY}, 32'd0);
        chk("single_pops", rd_ptr - rd0, 32'd1);

        // Eight back-to-back entries to bank B1
        base = nw;
        cnt0 = WR_CNT;
        for (int i = 0; i < 8; i++) push(18'h30000 + 18'(i), 16'h1000 + 16'(i));
        wait_writes("burst_wait", base + 8, 100);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst_a%0d", i), {14'd0, log_a[(base + i) % 512]}, 32'h30000 + i);
            chk($sformatf("burst_d%0d", i), {16'd0, log_d[(base + i) % 512]}, 32'h1000 + i);
            if (i > 0)
                chk($sformatf("burst_gap%0d", i),
                    log_t[(base + i) % 512] - log_t[(base + i - 1) % 512], 32'd3);
        end
        tick(2);
        chk("burst_cnt", {24'd0, WR_CNT} - cnt0, 32'd8);
        chk("burst_no_empty_pop", {31'd0, bad_pop}, 32'd0);

        // Bank A1 blocked for 10 cycles
        BANK_FREE = 4'b1101;
        cnt0 = WR_CNT;
        push(18'h10044, 16'h5A5A);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (VRAM_REQ !== 1'b0 || BUSY !== 1'b1) stable = 1'b0;
        end
        chk("blocked_no_req", {31'd0, stable}, 32'd1);
        chk("blocked_busy", {31'd0, BUSY}, 32'd1);
        BANK_FREE = 4'hF;
        tick();
        chk("unblocked_req", {31'd0, VRAM_REQ}, 32'd1);
        chk("unblocked_bank", {30'd0, VRAM_BANK}, 32'd1);
        tick(2);
        chk("unblocked_cnt", {24'd0, WR_CNT} - cnt0, 32'd1);

        // ACK withheld 20 cycles with BANK_FREE toggling
        ack_auto = 1'b0;
        cnt0 = WR_CNT;
        push(18'h20100, 16'h1234);
        wait_req("hold_wait_req", 10);
        a0 = VRAM_A;
        d0 = VRAM_D;
        chk("hold_a0", {14'd0, a0}, 32'h20100);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            BANK_FREE = (i % 2 == 0) ? 4'h0 : 4'hF;
            tick();
            if (VRAM_REQ !== 1'b1 || VRAM_A !== a0 || VRAM_D !== d0) stable = 1'b0;
        end
        chk("hold_stable", {31'd0, stable}, 32'd1);
        chk("hold_cnt", {24'd0, WR_CNT} - cnt0, 32'd0);
        BANK_FREE = 4'hF;
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("hold_release_req", {31'd0, VRAM_REQ}, 32'd0);
        chk("hold_release_cnt", {24'd0, WR_CNT} - cnt0, 32'd1);
        tick(2);
        cnt0 = WR_CNT;
        for (int i = 0; i < 3; i++) begin
            ack_man = 1'b1;
            tick();
            ack_man = 1'b0;
            tick();
        end
        chk("stray_ack_cnt", {24'd0, WR_CNT}, cnt0);
        chk("stray_ack_req", {31'd0, VRAM_REQ}, 32'd0);

        // Reset while waiting for ACK
        push(18'h00200, 16'hCAFE);
        wait_req("rst_mid_wait_req", 10);
        RST_N = 1'b0;
        wr_ptr = rd_ptr;
        #1;
        chk("rstmid_req", {31'd0, VRAM_REQ}, 32'd0);
        chk("rstmid_a", {14'd0, VRAM_A}, 32'd0);
        chk("rstmid_d", {16'd0, VRAM_D}, 32'd0);
        chk("rstmid_bank", {30'd0, VRAM_BANK}, 32'd0);
        chk("rstmid_cnt", {24'd0, WR_CNT}, 32'd0);
        chk("rstmid_pop", {31'd0, FIFO_RDREQ}, 32'd0);
        tick();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        ack_auto = 1'b1;
        base = nw;
        push(18'h00300, 16'hD00D);
        wait_writes("rstmid_drain", base + 1, 20);
        chk("rstmid_next_a", {14'd0, log_a[base % 512]}, 32'h00300);
        chk("rstmid_next_d", {16'd0, log_d[base % 512]}, 32'hD00D);
        tick(2);
        chk("rstmid_next_cnt", {24'd0, WR_CNT}, 32'd1);

        // 260 writes from a fresh reset: counter wraps to 4
        RST_N = 1'b0;
        tick();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        base = nw;
        for (int i = 0; i < 260; i++) push(18'(i * 5), 16'(i ^ 16'h00A5));
        wait_writes("wrap_wait", base + 260, 260 * 3 + 50);
        tick(2);
        chk("wrap_cnt", {24'd0, WR_CNT}, 32'd4);
        chk("wrap_last_a", {14'd0, log_a[(base + 259) % 512]}, 32'd1295);
        chk("wrap_last_d", {16'd0, log_d[(base + 259) % 512]}, 32'h0103 ^ 32'h00A5);
        chk("wrap_busy", {31'd0, BUSY}, 32'd0);
        chk("final_no_empty_pop", {31'd0, bad_pop}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vdp2_write_drain.md
VDP2_WRITE_DRAIN -- requirements
Module: vdp2_write_drain

Interface
REQ-001 Parameter ADDR_W, default 18: VRAM word-address width, A[18:1].
REQ-002 Parameter DATA_W, default 16: VRAM word width; ADDR_W+DATA_W SHALL equal 34.
REQ-003 CLK  in  1  sole clock; all state SHALL change on posedge CLK.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 FIFO_Q  in  34  head entry of the CPU write FIFO: [33:16] word address, [15:0] data; valid combinationally whenever FIFO_EMPTY=0.
REQ-006 FIFO_EMPTY  in  1  FIFO holds no entries.
REQ-007 FIFO_RDREQ  out  1  one-cycle pop of the head entry.
REQ-008 BANK_FREE  in  4  per-bank slot enable (bit0 A0, bit1 A1, bit2 B0, bit3 B1), sampled each cycle.
REQ-009 VRAM_REQ  out  1  write request to the VRAM arbiter.
REQ-010 VRAM_BANK  out  2  target bank = address[18:17].
REQ-011 VRAM_A  out  18  word address.
REQ-012 VRAM_D  out  16  write data.
REQ-013 VRAM_ACK  in  1  one-cycle pulse: the arbiter accepted the current write.
REQ-014 BUSY  out  1  high while the FIFO is non-empty or a write is held.
REQ-015 WR_CNT  out  8  count of completed writes.

Function
REQ-016 FSM states SHALL be IDLE, HOLD and WAIT.
REQ-017 IDLE with FIFO_EMPTY=0: latch FIFO_Q into the hold register, assert FIFO_RDREQ for exactly that cycle, go to HOLD.
REQ-018 FIFO_RDREQ SHALL never be asserted while FIFO_EMPTY=1 or while the hold register is occupied and not being released.
REQ-019 HOLD: assert VRAM_REQ registered in the next cycle only when BANK_FREE[VRAM_BANK]=1, then go to WAIT; otherwise stay in HOLD with VRAM_REQ=0.
REQ-020 WAIT: VRAM_REQ, VRAM_BANK, VRAM_A and VRAM_D SHALL stay stable until VRAM_ACK.
REQ-021 WAIT with VRAM_ACK=1: deassert VRAM_REQ next cycle and increment WR_CNT; if FIFO_EMPTY=0, pop and latch the next entry in the same cycle and go to HOLD; otherwise go to IDLE.
REQ-022 Back-to-back throughput SHALL be one write per 3 cycles when the bank is free and the arbiter acknowledges immediately.
REQ-023 Latency from FIFO_EMPTY falling in IDLE to VRAM_REQ high SHALL be 2 cycles when the bank is free.
REQ-024 VRAM_ACK outside WAIT SHALL be ignored.
REQ-025 BANK_FREE dropping during WAIT SHALL NOT withdraw VRAM_REQ.
REQ-026 WR_CNT SHALL wrap modulo 256 (255 -> 0).
REQ-027 BUSY = !FIFO_EMPTY | (state != IDLE), combinational.
REQ-028 Entries SHALL be written in FIFO order; no reordering or merging.

Reset
REQ-029 RST_N low SHALL asynchronously force state IDLE, FIFO_RDREQ=0, VRAM_REQ=0, VRAM_BANK=0, VRAM_A=0, VRAM_D=0 and WR_CNT=0.
REQ-030 Reset mid-write SHALL discard the held entry; the FIFO SHALL be reset by the same RST_N.
REQ-031 After RST_N rises, the first pop SHALL occur no earlier than the first posedge at which FIFO_EMPTY=0.

Structure
REQ-032 A shared package vdp2_pkg SHALL hold the state enum, the 34-bit entry field positions and the bank-index constants.
REQ-033 The block SHALL be one module without sub-modules, instantiated beside the write FIFO in the VDP2 top level.

Verification
REQ-034 Single entry A=0x00010, D=0xBEEF, BANK_FREE=4'hF, ACK 1 cycle after REQ -> one pop, REQ at +2 cycles with BANK=0, A=0x00010, D=0xBEEF; WR_CNT=1; BUSY low afterwards.
REQ-035 8 queued entries to bank B1, immediate ACK -> 8 writes in order, spaced 3 cycles apart; WR_CNT=8; no pop while FIFO_EMPTY=1.
REQ-036 Entry for bank A1 with BANK_FREE[1]=0 for 10 cycles -> no VRAM_REQ and BUSY=1; REQ appears 1 cycle after BANK_FREE[1] rises.
REQ-037 ACK withheld 20 cycles, BANK_FREE toggling -> REQ, A and D stable throughout; stray ACK pulses in IDLE -> WR_CNT unchanged.
REQ-038 RST_N pulsed low in WAIT -> all outputs zero immediately; after release, the next FIFO entry drains normally.
REQ-039 260 writes -> WR_CNT reads 4 after wrapping past 255.
